// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Shared types and constants for the pipeline hazard controller:
//   - HZ_REG_AW / HZ_GR0 : default register-index width and the hardwired-zero
//                          register index.
//   - fwd_sel_t          : EX operand-mux source encoding.
//   - shadow_t           : one shadow scoreboard entry {rd, rf_le, load} at the
//                          default index width.
//   - hz_state_t         : controller FSM state.
//   - pick_fwd()         : youngest-producer-wins forwarding priority.
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int HZ_REG_AW = 5;
  localparam int HZ_GR0    = 0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // read the register file
    FWD_EXMEM = 2'b01,  // producer sits in EX/MEM
    FWD_MEMWB = 2'b10,  // producer sits in MEM/WB
    FWD_WB    = 2'b11   // producer is on the writeback bus
  } fwd_sel_t;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] rd;
    logic                 rf_le;
    logic                 load;
  } shadow_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // The youngest in-flight producer holds the newest value of the register,
  // so EX beats MEM beats WB.
  function automatic fwd_sel_t pick_fwd(input logic m_ex,
                                        input logic m_mem,
                                        input logic m_wb);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (m_ex) begin
      sel = FWD_EXMEM;
    end else if (m_mem) begin
      sel = FWD_MEMWB;
    end else if (m_wb) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// -----------------------------------------------------------------------------
// hazard_shadow_stage
//
// One entry of the shadow destination-register scoreboard. Plain register with
// asynchronous active-high reset; an emptied entry (rf_le=0, load=0, rd=0) can
// never produce a match.
//
// Ports:
//   clk      in   pipeline clock
//   reset    in   asynchronous active-high reset
//   d_rd     in   incoming destination register index
//   d_rf_le  in   incoming register-file write enable
//   d_load   in   incoming "is a load" flag
//   q_rd     out  held destination register index
//   q_rf_le  out  held register-file write enable
//   q_load   out  held "is a load" flag
// -----------------------------------------------------------------------------
module hazard_shadow_stage
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_rf_le,
  input  logic              d_load,
  output logic [REG_AW-1:0] q_rd,
  output logic              q_rf_le,
  output logic              q_load
);

  logic [REG_AW-1:0] rd_reg;
  logic              rf_le_reg;
  logic              load_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg    <= '0;
      rf_le_reg <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      rd_reg    <= d_rd;
      rf_le_reg <= d_rf_le;
      load_reg  <= d_load;
    end
  end

  assign q_rd    = rd_reg;
  assign q_rf_le = rf_le_reg;
  assign q_load  = load_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Backward-facing hazard control for the 5-stage pipeline. A three-deep shadow
// scoreboard mirrors the destination registers in flight in EX, MEM and WB.
// The ID-stage source operands are compared against it to
//   - detect load-use hazards and freeze PC/IF-ID while a bubble goes to ID/EX,
//   - compute forwarding selects that are registered into the EX cycle.
//
// Optional feature (compile-time macro HAZARD_PERF_EN): adds a saturating
// 16-bit count of hazard (bubble-insert) cycles on output stall_count.
//
// Ports:
//   clk          in   pipeline clock
//   reset        in   asynchronous active-high reset
//   id_valid     in   a real instruction occupies ID
//   id_rs1       in   ID source register A
//   id_rs2       in   ID source register B
//   id_use_rs1   in   instruction reads rs1
//   id_use_rs2   in   instruction reads rs2
//   id_rd        in   ID destination register
//   id_rf_le     in   ID instruction writes the register file
//   id_load      in   ID instruction is a load
//   pc_le        out  load-enable to PC_FRONT / PC_BACK
//   if_id_le     out  load-enable to IF/ID
//   id_ex_nop    out  1 = inject all-zero control into ID/EX (bubble)
//   fwd_a        out  registered EX operand-A source (fwd_sel_t encoding)
//   fwd_b        out  registered EX operand-B source (fwd_sel_t encoding)
//   stalled      out  registered: a bubble was inserted last cycle
//   stall_count  out  (HAZARD_PERF_EN only) saturating hazard-cycle count
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int GR0    = HZ_GR0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_le,
  input  logic              id_load,
  output logic              pc_le,
  output logic              if_id_le,
  output logic              id_ex_nop,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stalled
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam logic [REG_AW-1:0] GR0_IDX = REG_AW'(GR0);
  localparam int NSTAGE = 3;  // 0 = EX, 1 = MEM, 2 = WB

  // ---------------------------------------------------------------------------
  // Shadow scoreboard: EX -> MEM -> WB chain
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] sh_rd      [NSTAGE];
  logic [NSTAGE-1:0] sh_rf_le;
  logic [NSTAGE-1:0] sh_load;

  logic [REG_AW-1:0] sh_rd_next [NSTAGE];
  logic [NSTAGE-1:0] sh_rf_le_next;
  logic [NSTAGE-1:0] sh_load_next;

  logic haz;

  // The EX entry only claims the write if the instruction really issues; an
  // invalid slot or a stalled instruction enters as a bubble. rd is copied
  // regardless because rf_le=0 already makes the entry inert.
  assign sh_rd_next[0]    = id_rd;
  assign sh_rf_le_next[0] = id_rf_le & id_valid & ~haz;
  assign sh_load_next[0]  = id_load  & id_valid & ~haz;

  genvar gi;
  generate
    for (gi = 1; gi < NSTAGE; gi++) begin : g_chain
      assign sh_rd_next[gi]    = sh_rd[gi-1];
      assign sh_rf_le_next[gi] = sh_rf_le[gi-1];
      assign sh_load_next[gi]  = sh_load[gi-1];
    end

    for (gi = 0; gi < NSTAGE; gi++) begin : g_shadow
      hazard_shadow_stage #(
        .REG_AW (REG_AW)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .d_rd    (sh_rd_next[gi]),
        .d_rf_le (sh_rf_le_next[gi]),
        .d_load  (sh_load_next[gi]),
        .q_rd    (sh_rd[gi]),
        .q_rf_le (sh_rf_le[gi]),
        .q_load  (sh_load[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Source-operand matching
  // ---------------------------------------------------------------------------
  // GR0 reads always return zero, so a GR0 source never depends on anyone,
  // even when an in-flight instruction "writes" GR0.
  logic src_a_live;
  logic src_b_live;
  logic [NSTAGE-1:0] match_a;
  logic [NSTAGE-1:0] match_b;

  assign src_a_live = id_valid & id_use_rs1 & (id_rs1 != GR0_IDX);
  assign src_b_live = id_valid & id_use_rs2 & (id_rs2 != GR0_IDX);

  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_match
      assign match_a[gi] = src_a_live & sh_rf_le[gi] & (sh_rd[gi] == id_rs1);
      assign match_b[gi] = src_b_live & sh_rf_le[gi] & (sh_rd[gi] == id_rs2);
    end
  endgenerate

  // A load's data is only available at the end of MEM, so a consumer directly
  // behind it must wait one cycle; after that the load sits in MEM and the
  // MEM/WB forward path covers it.
  assign haz = (match_a[0] | match_b[0]) & sh_load[0];

  // ---------------------------------------------------------------------------
  // Forwarding selects, registered into the EX cycle
  // ---------------------------------------------------------------------------
  fwd_sel_t sel_a_next;
  fwd_sel_t sel_b_next;
  fwd_sel_t fwd_a_reg;
  fwd_sel_t fwd_b_reg;

  assign sel_a_next = pick_fwd(match_a[0], match_a[1], match_a[2]);
  assign sel_b_next = pick_fwd(match_b[0], match_b[1], match_b[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else if (haz) begin
      // The instruction moving into EX is a bubble: no operand source needed.
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else begin
      fwd_a_reg <= sel_a_next;
      fwd_b_reg <= sel_b_next;
    end
  end

  assign fwd_a = fwd_a_reg;
  assign fwd_b = fwd_b_reg;

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  hz_state_t state_reg;
  hz_state_t state_next;
  logic      pc_le_next;
  logic      nop_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // STALL never chains to itself: after one bubble the load has moved to MEM,
  // where the hazard no longer applies. A second hazard from a different load
  // goes back through RUN.
  always_comb begin
    state_next = state_reg;
    pc_le_next = ~haz;
    nop_next   = haz;
    case (state_reg)
      RUN:     if (haz) state_next = STALL;
      STALL:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign pc_le     = pc_le_next;
  assign if_id_le  = pc_le_next;
  assign id_ex_nop = nop_next;
  assign stalled   = (state_reg == STALL);

  // ---------------------------------------------------------------------------
  // Optional hazard-cycle counter
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (haz && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed vectors drive the ID-stage inputs one per cycle (just after the
// rising edge). Each vector carries hand-computed expectations for what the
// DUT shows during that cycle: the combinational stall outputs for the vector
// itself and the registered fwd/stalled values produced by the previous
// vector. Expectations are queued at issue time; a monitor pops and compares
// them on the falling edge. Reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_rf_le;
  logic       id_load;
  logic       pc_le;
  logic       if_id_le;
  logic       id_ex_nop;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stalled;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count;
`endif

  pipeline_hazard_ctrl #(
    .REG_AW (5),
    .GR0    (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_rf_le   (id_rf_le),
    .id_load    (id_load),
    .pc_le      (pc_le),
    .if_id_le   (if_id_le),
    .id_ex_nop  (id_ex_nop),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stalled    (stalled)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rf;
    logic       ld;
    logic       le;
    logic       nop;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
  } vec_t;

  typedef struct {
    int         row;
    logic       le;
    logic       nop;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
  } exp_t;

  vec_t vecs1[$];
  vec_t vecs2[$];
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int row,
                       input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, want);
    end
  endtask

  task automatic add(ref vec_t q[$],
                     input logic v, input int rs1, input int rs2,
                     input logic u1, input logic u2, input int rd,
                     input logic rf, input logic ld,
                     input logic le, input logic nop,
                     input int fa, input int fb, input logic st);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = u1; t.u2 = u2;
    t.rd = 5'(rd); t.rf = rf; t.ld = ld;
    t.le = le; t.nop = nop; t.fa = 2'(fa); t.fb = 2'(fb); t.st = st;
    q.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int row);
    exp_t e;
    id_valid   = t.v;
    id_rs1     = t.rs1;
    id_rs2     = t.rs2;
    id_use_rs1 = t.u1;
    id_use_rs2 = t.u2;
    id_rd      = t.rd;
    id_rf_le   = t.rf;
    id_load    = t.ld;
    e.row = row; e.le = t.le; e.nop = t.nop;
    e.fa = t.fa; e.fb = t.fb; e.st = t.st;
    sb_q.push_back(e);
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest queued
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("txn row=%0d pc_le=%0b if_id_le=%0b nop=%0b fwd_a=%0d fwd_b=%0d stalled=%0b",
                 e.row, pc_le, if_id_le, id_ex_nop, fwd_a, fwd_b, stalled);
        check("pc_le",     e.row, 16'(pc_le),     16'(e.le));
        check("if_id_le",  e.row, 16'(if_id_le),  16'(e.le));
        check("id_ex_nop", e.row, 16'(id_ex_nop), 16'(e.nop));
        check("fwd_a",     e.row, 16'(fwd_a),     16'(e.fa));
        check("fwd_b",     e.row, 16'(fwd_b),     16'(e.fb));
        check("stalled",   e.row, 16'(stalled),   16'(e.st));
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int row;
    int waits;
    //             v  rs1 rs2 u1 u2  rd rf ld | le nop fa fb st
    add(vecs1, 1,  1,  2, 1, 1,  3, 1, 0,  1, 0, 0, 0, 0); // 0  add r3
    add(vecs1, 1,  3,  4, 1, 1,  5, 1, 0,  1, 0, 0, 0, 0); // 1  add r5<-r3,r4
    add(vecs1, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0); // 2  EX: fwd_a=01
    add(vecs1, 1,  6,  0, 1, 0,  7, 1, 1,  1, 0, 0, 0, 0); // 3  load r7
    add(vecs1, 1,  7,  7, 1, 1,  8, 1, 0,  0, 1, 0, 0, 0); // 4  load-use stall
    add(vecs1, 1,  7,  7, 1, 1,  8, 1, 0,  1, 0, 0, 0, 1); // 5  held, stalled
    add(vecs1, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 2, 2, 0); // 6  both 10
    add(vecs1, 1,  6,  0, 1, 0,  7, 1, 1,  1, 0, 0, 0, 0); // 7  load r7
    add(vecs1, 1,  1,  2, 1, 1, 10, 1, 0,  1, 0, 0, 0, 0); // 8  independent
    add(vecs1, 1,  7,  2, 1, 1, 11, 1, 0,  1, 0, 0, 0, 0); // 9  use r7, no stall
    add(vecs1, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 2, 0, 0); // 10 fwd_a=10
    add(vecs1, 1,  1,  2, 1, 1,  9, 1, 0,  1, 0, 0, 0, 0); // 11 producer r9
    add(vecs1, 1,  1,  2, 1, 1, 12, 1, 0,  1, 0, 0, 0, 0); // 12
    add(vecs1, 1,  1,  2, 1, 1, 13, 1, 0,  1, 0, 0, 0, 0); // 13
    add(vecs1, 1,  9,  0, 1, 1, 14, 1, 0,  1, 0, 0, 0, 0); // 14 r9 from WB, rs2=GR0
    add(vecs1, 1,  1,  0, 1, 0,  0, 1, 1,  1, 0, 3, 0, 0); // 15 load r0
    add(vecs1, 1,  0,  0, 1, 1, 15, 1, 0,  1, 0, 0, 0, 0); // 16 read GR0: no stall
    add(vecs1, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0); // 17 fwd 00
    add(vecs1, 1, 15, 15, 0, 1, 16, 1, 0,  1, 0, 0, 0, 0); // 18 rs1 unused
    add(vecs1, 0, 16,  0, 1, 0, 20, 1, 0,  1, 0, 0, 2, 0); // 19 invalid, would match
    add(vecs1, 1, 20,  0, 1, 0, 21, 1, 0,  1, 0, 0, 0, 0); // 20 invalid left bubble
    add(vecs1, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0); // 21
    add(vecs1, 1,  1,  0, 1, 0,  4, 1, 1,  1, 0, 0, 0, 0); // 22 load r4
    add(vecs1, 1,  4,  0, 1, 0,  5, 1, 1,  0, 1, 0, 0, 0); // 23 load r5<-r4 stall
    add(vecs1, 1,  4,  0, 1, 0,  5, 1, 1,  1, 0, 0, 0, 1); // 24 held
    add(vecs1, 1,  1,  5, 1, 1,  6, 1, 0,  0, 1, 2, 0, 0); // 25 second load-use
    add(vecs1, 1,  1,  5, 1, 1,  6, 1, 0,  1, 0, 0, 0, 1); // 26 held
    add(vecs1, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 2, 0); // 27 fwd_b=10
    add(vecs1, 1,  6,  0, 1, 0,  7, 1, 1,  1, 0, 0, 0, 0); // 28 load r7<-r6
    add(vecs1, 1,  7,  7, 1, 1,  8, 1, 0,  0, 1, 2, 0, 0); // 29 stall; reset hits here

    add(vecs2, 1,  7,  7, 1, 1,  8, 1, 0,  1, 0, 0, 0, 0); // 30 retry after reset
    add(vecs2, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0); // 31
    add(vecs2, 1,  8,  0, 1, 0,  9, 1, 0,  1, 0, 0, 0, 0); // 32 use r8
    add(vecs2, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 2, 0, 0); // 33
    add(vecs2, 1,  2,  0, 1, 0,  1, 1, 1,  1, 0, 0, 0, 0); // 34 load r1
    add(vecs2, 1,  1,  0, 1, 1,  3, 1, 0,  0, 1, 0, 0, 0); // 35 stall
    add(vecs2, 1,  1,  0, 1, 1,  3, 1, 0,  1, 0, 0, 0, 1); // 36 held
    add(vecs2, 1,  0,  0, 1, 0,  2, 1, 1,  1, 0, 2, 0, 0); // 37 load r2<-r0
    add(vecs2, 1,  5,  2, 1, 1,  4, 1, 0,  0, 1, 0, 0, 0); // 38 stall on rs2
    add(vecs2, 1,  5,  2, 1, 1,  4, 1, 0,  1, 0, 0, 0, 1); // 39 held
    add(vecs2, 0,  0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 2, 0); // 40

    // Reset state
    reset = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; id_rd = '0; id_rf_le = 1'b0; id_load = 1'b0;
    #1;
    check("rst_pc_le",    -1, 16'(pc_le),     16'd1);
    check("rst_if_id_le", -1, 16'(if_id_le),  16'd1);
    check("rst_nop",      -1, 16'(id_ex_nop), 16'd0);
    check("rst_fwd_a",    -1, 16'(fwd_a),     16'd0);
    check("rst_fwd_b",    -1, 16'(fwd_b),     16'd0);
    check("rst_stalled",  -1, 16'(stalled),   16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    row = 0;
    foreach (vecs1[i]) begin
      @(posedge clk);
      #1;
`ifdef HAZARD_PERF_EN
      if (row == 28) check("stall_count_3", row, stall_count, 16'd3);
`endif
      apply(vecs1[i], row);
      row++;
    end

    // Reset asserted in the middle of the load-use stall cycle
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pc_le",    29, 16'(pc_le),     16'd1);
    check("midrst_if_id_le", 29, 16'(if_id_le),  16'd1);
    check("midrst_nop",      29, 16'(id_ex_nop), 16'd0);
    check("midrst_fwd_a",    29, 16'(fwd_a),     16'd0);
    check("midrst_fwd_b",    29, 16'(fwd_b),     16'd0);
    check("midrst_stalled",  29, 16'(stalled),   16'd0);
    @(posedge clk);
    #1;
    check("midrst_edge_stalled", 29, 16'(stalled), 16'd0);
    check("midrst_edge_fwd_a",   29, 16'(fwd_a),   16'd0);
`ifdef HAZARD_PERF_EN
    check("midrst_count", 29, stall_count, 16'd0);
`endif
    reset = 1'b0;

    foreach (vecs2[i]) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      apply(vecs2[i], row);
`ifdef HAZARD_PERF_EN
      if (row == 34) begin
        force dut.stall_count_reg = 16'hFFFE;
        #1;
        release dut.stall_count_reg;
      end
      if (row == 37) check("stall_count_sat1", row, stall_count, 16'hFFFF);
`endif
      row++;
    end

    // Drain the scoreboard with a bounded wait
    waits = 0;
    while (sb_q.size() > 0 && waits < 5) begin
      @(posedge clk);
      waits++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending want=0", sb_q.size());
    end
`ifdef HAZARD_PERF_EN
    check("stall_count_sat2", row, stall_count, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
